clk_div_multi: RTL and testbench
================================

CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 Parameter CH, default 2: number of independent divider channels, range 1..8.
REQ-002 Parameter DIV_W, default 17: width of each half-period divisor.
REQ-003 Parameter DEF_DIV, default 50000: half-period divisor loaded into every channel at reset.
REQ-004 Parameter FRAC_W, default 8: fractional increment width; used only when FRAC_DIV_EN is defined.
REQ-005 clk_in  input  1  single system clock; all logic on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 ch_en  input  CH  per-channel run enable.
REQ-008 div_wr  input  CH  per-channel one-cycle divisor write strobe.
REQ-009 div_data  input  DIV_W  divisor value; shared by all channels and qualified by div_wr.
REQ-010 frac_data  input  FRAC_W  fractional increment, written with div_wr; present only with FRAC_DIV_EN.
REQ-011 clk_out  output  CH  divided clocks, 50% duty in integer mode.
REQ-012 tick  output  CH  one-cycle strobe per channel, high in the cycle clk_out goes 0->1.
REQ-013 div_pend  output  CH  high while a written divisor awaits application.

Function
REQ-014 Each channel has an active divisor D, a shadow divisor, a DIV_W-bit counter and a pend flag; all outputs are registered.
REQ-015 A D value of 0 is treated as 1.
REQ-016 Enabled channel: the counter increments each cycle; at count D-1 it wraps to 0 and clk_out toggles in that cycle.
REQ-017 Resulting period is 2*D clk_in cycles; D=1 gives clk_in/2.
REQ-018 tick asserts for exactly one cycle, registered alongside the 0->1 toggle of clk_out.
REQ-019 div_wr[i] loads the shadow register and sets div_pend[i] in the next cycle.
REQ-020 While ch_en[i]=1, shadow->active transfer occurs only at a wrap; the new half-period starts with the new D, so no shortened or glitched half-period ever appears.
REQ-021 While ch_en[i]=0, the shadow transfers on the cycle after the write.
REQ-022 div_pend clears in the same cycle the transfer occurs.
REQ-023 A second div_wr before transfer overwrites the shadow; the last write wins.
REQ-024 div_wr coinciding with a wrap: the wrap uses the old shadow (if pending) and the new value becomes pending.
REQ-025 ch_en[i]=0: counter held at 0, clk_out[i]=0, tick[i]=0.
REQ-026 Deasserting ch_en mid-period forces clk_out low next cycle; the stretched low half-period is accepted.
REQ-027 ch_en rising: first 0->1 toggle occurs D cycles later.
REQ-028 Channels are fully independent; simultaneous writes to multiple channels are legal.

Reset
REQ-029 rst_n low asynchronously forces: clk_out=0, tick=0, div_pend=0, counters=0, active and shadow D=DEF_DIV, fractional accumulators=0.
REQ-030 Release of rst_n is synchronised inside the block; counting starts on the second clk_in edge after release.

Configuration
REQ-031 Macro CLK_DIV_FRAC_DIV_EN defined: each channel holds an active/shadow FRAC_W increment F and a FRAC_W accumulator; at each wrap acc<=acc+F, and on carry-out the next half-period lasts D+1 cycles; F transfers with D; average half-period = D + F/2^FRAC_W.
REQ-032 Macro absent: frac_data port, accumulators and F registers do not exist; behaviour is pure integer.

Verification
REQ-033 Reset release, DEF_DIV=4, ch_en=1 -> clk_out period 8 cycles, 4 high/4 low, one tick per period.
REQ-034 D=10 running, div_wr with 3 mid-half-period -> div_pend=1 until next wrap; current half-period completes 10 cycles, subsequent ones 3 cycles.
REQ-035 div_data=0 written on a disabled channel, then enabled -> clk_out toggles every cycle and tick high every second cycle.
REQ-036 ch_en dropped at count 5 of D=8 -> clk_out=0 next cycle and held; re-enable -> first rising edge 8 cycles later.
REQ-037 rst_n pulsed low mid-count asynchronously -> all outputs 0 without a clock edge; D returns to DEF_DIV.
REQ-038 CLK_DIV_FRAC_DIV_EN, D=4, F=128, FRAC_W=8 -> half-periods alternate 4,5; 16 half-periods span 72 cycles.

Source files
------------

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with shadowed, glitch-free divisor updates.
// Define CLK_DIV_FRAC_DIV_EN to add a fractional (D + F/2^FRAC_W) half-period mode.

module clk_div_ch #(
    parameter int DIV_W   = 17,
    parameter int DEF_DIV = 50000,
    parameter int FRAC_W  = 8
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             run,
    input  logic             en,
    input  logic             wr,
    input  logic [DIV_W-1:0] div_data,
`ifdef CLK_DIV_FRAC_DIV_EN
    input  logic [FRAC_W-1:0] frac_data,
`endif
    output logic             clk_out,
    output logic             tick,
    output logic             pend
);

    logic [DIV_W-1:0] div_act, div_shd, cnt, eff_d, term;
    logic             extra, wrap, xfer;

    assign eff_d = (div_act == '0) ? DIV_W'(1) : div_act;
    // Terminal count of the current half-period; a fractional carry stretches it by one.
    assign term  = eff_d - DIV_W'(1) + DIV_W'(extra);
    assign wrap  = en && (cnt == term);
    assign xfer  = pend && (!en || wrap);

`ifdef CLK_DIV_FRAC_DIV_EN
    logic [FRAC_W-1:0] frac_act, frac_shd, acc;
    logic [FRAC_W:0]   acc_sum;

    assign acc_sum = {1'b0, acc} + {1'b0, frac_act};

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            frac_act <= '0;
            frac_shd <= '0;
            acc      <= '0;
            extra    <= 1'b0;
        end else if (run) begin
            if (!en) begin
                extra <= 1'b0;
            end else if (wrap) begin
                acc   <= acc_sum[FRAC_W-1:0];
                extra <= acc_sum[FRAC_W];
            end
            if (xfer) frac_act <= frac_shd;
            if (wr)   frac_shd <= frac_data;
        end
    end
`else
    assign extra = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            div_act <= DIV_W'(DEF_DIV);
            div_shd <= DIV_W'(DEF_DIV);
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            pend    <= 1'b0;
        end else if (run) begin
            if (!en) begin
                cnt     <= '0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
            end else if (wrap) begin
                cnt     <= '0;
                clk_out <= ~clk_out;
                tick    <= ~clk_out;
            end else begin
                cnt  <= cnt + DIV_W'(1);
                tick <= 1'b0;
            end
            // A write landing on a transfer edge becomes the next pending value.
            if (xfer) div_act <= div_shd;
            if (wr) begin
                div_shd <= div_data;
                pend    <= 1'b1;
            end else if (xfer) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

module clk_div_multi #(
    parameter int CH      = 2,
    parameter int DIV_W   = 17,
    parameter int DEF_DIV = 50000,
    parameter int FRAC_W  = 8
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic [CH-1:0]     ch_en,
    input  logic [CH-1:0]     div_wr,
    input  logic [DIV_W-1:0]  div_data,
`ifdef CLK_DIV_FRAC_DIV_EN
    input  logic [FRAC_W-1:0] frac_data,
`endif
    output logic [CH-1:0]     clk_out,
    output logic [CH-1:0]     tick,
    output logic [CH-1:0]     div_pend
);

    // Reset release is re-timed through one flop, so the first count lands on the second edge.
    logic run;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) run <= 1'b0;
        else        run <= 1'b1;
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        clk_div_ch #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV),
            .FRAC_W  (FRAC_W)
        ) u_ch (
            .clk_in    (clk_in),
            .rst_n     (rst_n),
            .run       (run),
            .en        (ch_en[i]),
            .wr        (div_wr[i]),
            .div_data  (div_data),
`ifdef CLK_DIV_FRAC_DIV_EN
            .frac_data (frac_data),
`endif
            .clk_out   (clk_out[i]),
            .tick      (tick[i]),
            .pend      (div_pend[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: a half-period event model predicts every output cycle.
module tb_clk_div_multi;

    localparam int CH      = 2;
    localparam int DIV_W   = 17;
    localparam int DEF_DIV = 4;
    localparam int FRAC_W  = 8;
    localparam int FSCALE  = 1 << FRAC_W;

    logic              clk_in;
    logic              rst_n;
    logic [CH-1:0]     ch_en, div_wr;
    logic [DIV_W-1:0]  div_data;
    logic [FRAC_W-1:0] frac_data;
    logic [CH-1:0]     clk_out, tick, div_pend;

    clk_div_multi #(.CH(CH), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV), .FRAC_W(FRAC_W)) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .ch_en     (ch_en),
        .div_wr    (div_wr),
        .div_data  (div_data),
`ifdef CLK_DIV_FRAC_DIV_EN
        .frac_data (frac_data),
`endif
        .clk_out   (clk_out),
        .tick      (tick),
        .div_pend  (div_pend)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [CH-1:0] clk;
        logic [CH-1:0] tck;
        logic [CH-1:0] pnd;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: each channel is a level plus the edge index of its next toggle.
    int  m_n;
    int  m_dact[CH], m_dshd[CH], m_fact[CH], m_fshd[CH], m_acc[CH], m_tnext[CH];
    bit  m_lvl[CH], m_pend[CH];
    logic [CH-1:0] en_r;

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic model_reset();
        m_n = 0;
        for (int c = 0; c < CH; c++) begin
            m_dact[c] = DEF_DIV; m_dshd[c] = DEF_DIV;
            m_fact[c] = 0; m_fshd[c] = 0; m_acc[c] = 0;
            m_lvl[c] = 0; m_pend[c] = 0; m_tnext[c] = 0;
        end
    endtask

    task automatic model_step(input logic [CH-1:0] en, input logic [CH-1:0] wr,
                              input int d, input int f);
        exp_t e;
        m_n++;
        e = '0;
        for (int c = 0; c < CH; c++) begin
            bit tog, xfer;
            int extra;
            tog = 0; xfer = 0; extra = 0;
            if (m_n < 2) begin
                m_tnext[c] = m_n + eff(m_dact[c]);
            end else begin
                if (!en[c]) begin
                    m_lvl[c] = 0;
                    xfer = m_pend[c];
                end else if (m_n == m_tnext[c]) begin
                    tog = 1;
                    m_lvl[c] = !m_lvl[c];
                    m_acc[c] = m_acc[c] + m_fact[c];
                    if (m_acc[c] >= FSCALE) begin
                        m_acc[c] -= FSCALE;
                        extra = 1;
                    end
                    xfer = m_pend[c];
                end
                if (xfer) begin
                    m_dact[c] = m_dshd[c];
                    m_fact[c] = m_fshd[c];
                    m_pend[c] = 0;
                end
                if (!en[c])  m_tnext[c] = m_n + eff(m_dact[c]);
                else if (tog) m_tnext[c] = m_n + eff(m_dact[c]) + extra;
                if (wr[c]) begin
                    m_dshd[c] = d;
`ifdef CLK_DIV_FRAC_DIV_EN
                    m_fshd[c] = f;
`else
                    m_fshd[c] = 0;
`endif
                    m_pend[c] = 1;
                end
                e.tck[c] = tog && m_lvl[c];
            end
            e.clk[c] = m_lvl[c];
            e.pnd[c] = m_pend[c];
        end
        q.push_back(e);
    endtask

    task automatic step(input logic [CH-1:0] en, input logic [CH-1:0] wr,
                        input int d, input int f);
        @(negedge clk_in);
        ch_en = en; div_wr = wr;
        div_data = DIV_W'(d); frac_data = FRAC_W'(f);
        en_r = en;
        model_step(en, wr, d, f);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(en_r, '0, 0, 0);
    endtask

    task automatic release_reset(input logic [CH-1:0] en);
        @(negedge clk_in);
        model_reset();
        rst_n = 1'b1;
        ch_en = en; div_wr = '0; en_r = en;
        model_step(en, '0, 0, 0);
    endtask

    task automatic check_zero(input string name);
        n_tests++;
        if ({clk_out, tick, div_pend} !== '0) begin
            n_fail++;
            $display("FAIL %s: clk_out=%b tick=%b div_pend=%b, required all zero",
                     name, clk_out, tick, div_pend);
        end
    endtask

    // Monitor: every clock edge presents a new output word; compare it with the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_in);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_tests++;
                if (clk_out !== e.clk || tick !== e.tck || div_pend !== e.pnd) begin
                    n_fail++;
                    $display("FAIL cycle %0d @%0t: clk_out=%b tick=%b div_pend=%b, required clk_out=%b tick=%b div_pend=%b",
                             m_n, $time, clk_out, tick, div_pend, e.clk, e.tck, e.pnd);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b1; ch_en = '0; div_wr = '0; div_data = '0; frac_data = '0; en_r = '0;
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_zero("reset_state");
        repeat (3) @(negedge clk_in);

        // DEF_DIV=4 straight out of reset: 8-cycle period, 4 high / 4 low.
        release_reset('1);
        idle(40);

        // ch0: D=10 applied, then D=3 written mid-half-period.
        step(en_r, 2'b01, 10, 0);
        idle(30);
        idle(4);
        step(en_r, 2'b01, 3, 0);
        idle(30);

        // ch1: D=0 written while disabled, then enabled -> clk_in/2.
        step(2'b01, '0, 0, 0);
        step(2'b01, 2'b10, 0, 0);
        idle(3);
        step(2'b11, '0, 0, 0);
        idle(12);

        // ch0: D=8, drop enable mid-count, hold, re-enable.
        step(en_r, 2'b01, 8, 0);
        idle(20);
        idle(5);
        step(2'b10, '0, 0, 0);
        idle(10);
        step(2'b11, '0, 0, 0);
        idle(30);

        // Back-to-back writes on both channels: last write wins; write on a wrap edge.
        step(en_r, 2'b11, 6, 0);
        step(en_r, 2'b11, 2, 0);
        idle(25);

        // Asynchronous reset between edges.
        @(negedge clk_in);
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        repeat (2) @(negedge clk_in);
        release_reset('1);
        idle(20);

`ifdef CLK_DIV_FRAC_DIV_EN
        // D=4, F=128: half-periods alternate 4,5.
        step(en_r, 2'b01, 4, 128);
        idle(100);
`endif

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            logic [CH-1:0] en, wr;
            en = en_r; wr = '0;
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 23) == 0) en[c] = ~en[c];
                if ($urandom_range(0, 19) == 0) wr[c] = 1'b1;
            end
            step(en, wr, int'($urandom_range(0, 12)), int'($urandom_range(0, FSCALE - 1)));
        end

        idle(2);
        @(negedge clk_in);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
